// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared-datapath core: sequences fetch, decode,
// execute, memory and write-back for lw, sw, beq and R-type, and counts retirements.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        pc_source,
    output logic        ir_write,
    output logic        mem_read,
    output logic        iord,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        illegal_insn,
    output logic [31:0] instr_count,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        WB_MEM   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        WB_R     = 4'd7,
        BR_TGT   = 4'd8,
        BRANCH   = 4'd9,
        ILLEGAL  = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state_q, state_d;
    logic   retire;

    // funct7_5 is consumed by the ALU decoder when alu_op = 10, not by this FSM.
    logic unused_funct7_5;
    assign unused_funct7_5 = funct7_5;

    assign state = state_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            instr_count <= 32'd0;
        end else begin
            state_q     <= state_d;
            instr_count <= instr_count + {31'd0, retire};
        end
    end

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        pc_en        = 1'b0;
        pc_source    = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        iord         = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        illegal_insn = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_RTYPE:          state_d = EXEC_R;
                    OP_BRANCH:         state_d = BR_TGT;
                    default:           state_d = ILLEGAL;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = WB_MEM;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
                state_d   = WB_R;
            end
            WB_R: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            BR_TGT: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                state_d   = BRANCH;
            end
            BRANCH: begin
                // Only beq is supported; other funct3 values fall through untaken.
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                pc_source = 1'b1;
                pc_en     = (funct3 == 3'b000) && zero;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            ILLEGAL: begin
                illegal_insn = 1'b1;
                state_d      = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences push expected
// per-cycle state/controls/count; a monitor pops and compares on each falling edge.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, pc_source, ir_write, mem_read, iord, mem_write;
    logic        reg_write, mem_to_reg, illegal_insn;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic [31:0] instr_count;
    logic [3:0]  state;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .pc_source    (pc_source),
        .ir_write     (ir_write),
        .mem_read     (mem_read),
        .iord         (iord),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .illegal_insn (illegal_insn),
        .instr_count  (instr_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2,
                           S_MEM_RD = 4'd3, S_WB_MEM = 4'd4, S_MEM_WR = 4'd5,
                           S_EXEC_R = 4'd6, S_WB_R = 4'd7, S_BR_TGT = 4'd8,
                           S_BRANCH = 4'd9, S_ILLEGAL = 4'd10;

    // Control word: pc_en pc_source ir_write mem_read iord mem_write reg_write
    //               mem_to_reg alu_src_a[2] alu_src_b[2] alu_op[2] illegal_insn
    localparam logic [14:0] C_FETCH_WAIT = 15'b0_0_0_1_0_0_0_0_00_01_00_0;
    localparam logic [14:0] C_FETCH_RDY  = 15'b1_0_1_1_0_0_0_0_00_01_00_0;
    localparam logic [14:0] C_DECODE     = 15'b0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [14:0] C_MEM_ADDR   = 15'b0_0_0_0_0_0_0_0_01_10_00_0;
    localparam logic [14:0] C_MEM_RD     = 15'b0_0_0_1_1_0_0_0_00_00_00_0;
    localparam logic [14:0] C_WB_MEM     = 15'b0_0_0_0_0_0_1_1_00_00_00_0;
    localparam logic [14:0] C_MEM_WR     = 15'b0_0_0_0_1_1_0_0_00_00_00_0;
    localparam logic [14:0] C_EXEC_R     = 15'b0_0_0_0_0_0_0_0_01_00_10_0;
    localparam logic [14:0] C_WB_R       = 15'b0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [14:0] C_BR_TGT     = 15'b0_0_0_0_0_0_0_0_10_10_00_0;
    localparam logic [14:0] C_BR_TAKEN   = 15'b1_1_0_0_0_0_0_0_01_00_01_0;
    localparam logic [14:0] C_BR_NOT     = 15'b0_1_0_0_0_0_0_0_01_00_01_0;
    localparam logic [14:0] C_ILLEGAL    = 15'b0_0_0_0_0_0_0_0_00_00_00_1;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                           OP_R  = 7'b0110011, OP_BEQ = 7'b1100011,
                           OP_AUIPC = 7'b0010111;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [14:0] ctrl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    event        chk_now;
    logic [14:0] act_ctrl;

    assign act_ctrl = {pc_en, pc_source, ir_write, mem_read, iord, mem_write,
                       reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_insn};

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or chk_now);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                if (state !== e.st || act_ctrl !== e.ctrl || instr_count !== e.cnt) begin
                    miscompares++;
                    $display("FAIL %s: got state=%0d ctrl=%b count=%h, want state=%0d ctrl=%b count=%h",
                             e.name, state, act_ctrl, instr_count, e.st, e.ctrl, e.cnt);
                end
            end
        end
    end

    task automatic expect_now(input string name, input logic [3:0] st,
                              input logic [14:0] ctrl, input logic [31:0] cnt);
        exp_t e;
        e.name = name; e.st = st; e.ctrl = ctrl; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    // Queue one cycle's expectation, then advance to just after the next rising edge.
    task automatic step(input string name, input logic [3:0] st,
                        input logic [14:0] ctrl, input logic [31:0] cnt);
        expect_now(name, st, ctrl, cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        step("reset_state", S_FETCH, C_FETCH_WAIT, 32'd0);
        rst_n = 1'b1;

        // R-type, zero-wait: 0,1,6,7,0
        mem_ready = 1'b1; opcode = OP_R; funct7_5 = 1'b1;
        step("r_fetch",  S_FETCH,  C_FETCH_RDY, 32'd0);
        step("r_decode", S_DECODE, C_DECODE,    32'd0);
        step("r_exec",   S_EXEC_R, C_EXEC_R,    32'd0);
        step("r_wb",     S_WB_R,   C_WB_R,      32'd0);

        // lw with two wait cycles in MEM_RD: 7 cycles total
        opcode = OP_LW; funct7_5 = 1'b0;
        step("lw_fetch", S_FETCH,    C_FETCH_RDY, 32'd1);
        step("lw_dec",   S_DECODE,   C_DECODE,    32'd1);
        step("lw_addr",  S_MEM_ADDR, C_MEM_ADDR,  32'd1);
        mem_ready = 1'b0;
        step("lw_wait1", S_MEM_RD,   C_MEM_RD,    32'd1);
        step("lw_wait2", S_MEM_RD,   C_MEM_RD,    32'd1);
        mem_ready = 1'b1;
        step("lw_rd",    S_MEM_RD,   C_MEM_RD,    32'd1);
        step("lw_wb",    S_WB_MEM,   C_WB_MEM,    32'd1);

        // beq taken
        opcode = OP_BEQ; funct3 = 3'b000; zero = 1'b1;
        step("beqt_fetch", S_FETCH,  C_FETCH_RDY, 32'd2);
        step("beqt_dec",   S_DECODE, C_DECODE,    32'd2);
        step("beqt_tgt",   S_BR_TGT, C_BR_TGT,    32'd2);
        step("beqt_br",    S_BRANCH, C_BR_TAKEN,  32'd2);

        // beq not taken
        zero = 1'b0;
        step("beqn_fetch", S_FETCH,  C_FETCH_RDY, 32'd3);
        step("beqn_dec",   S_DECODE, C_DECODE,    32'd3);
        step("beqn_tgt",   S_BR_TGT, C_BR_TGT,    32'd3);
        step("beqn_br",    S_BRANCH, C_BR_NOT,    32'd3);

        // funct3 != 000 with zero = 1: never taken, still retires
        funct3 = 3'b001; zero = 1'b1;
        step("bne_fetch", S_FETCH,  C_FETCH_RDY, 32'd4);
        step("bne_dec",   S_DECODE, C_DECODE,    32'd4);
        step("bne_tgt",   S_BR_TGT, C_BR_TGT,    32'd4);
        step("bne_br",    S_BRANCH, C_BR_NOT,    32'd4);
        funct3 = 3'b000; zero = 1'b0;

        // illegal opcode: 0,1,10,0 and count unchanged
        opcode = OP_AUIPC;
        step("ill_fetch", S_FETCH,   C_FETCH_RDY, 32'd5);
        step("ill_dec",   S_DECODE,  C_DECODE,    32'd5);
        step("ill_pulse", S_ILLEGAL, C_ILLEGAL,   32'd5);

        // sw with one FETCH wait and one MEM_WR wait
        opcode = OP_SW; mem_ready = 1'b0;
        step("sw_fwait",  S_FETCH,    C_FETCH_WAIT, 32'd5);
        mem_ready = 1'b1;
        step("sw_fetch",  S_FETCH,    C_FETCH_RDY,  32'd5);
        step("sw_dec",    S_DECODE,   C_DECODE,     32'd5);
        step("sw_addr",   S_MEM_ADDR, C_MEM_ADDR,   32'd5);
        mem_ready = 1'b0;
        step("sw_wwait",  S_MEM_WR,   C_MEM_WR,     32'd5);
        mem_ready = 1'b1;
        step("sw_wr",     S_MEM_WR,   C_MEM_WR,     32'd5);

        // sw abandoned by asynchronous reset while stalled in MEM_WR
        step("swr_fetch", S_FETCH,    C_FETCH_RDY,  32'd6);
        step("swr_dec",   S_DECODE,   C_DECODE,     32'd6);
        step("swr_addr",  S_MEM_ADDR, C_MEM_ADDR,   32'd6);
        mem_ready = 1'b0;
        step("swr_wwait", S_MEM_WR,   C_MEM_WR,     32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("async_reset", S_FETCH, C_FETCH_WAIT, 32'd0);
        -> chk_now;
        #1;
        step("reset_hold", S_FETCH, C_FETCH_WAIT, 32'd0);
        rst_n = 1'b1;

        // counter wrap: preload all-ones, retire one sw
        force dut.instr_count = 32'hFFFF_FFFF;
        step("force_cnt", S_FETCH, C_FETCH_WAIT, 32'hFFFF_FFFF);
        release dut.instr_count;
        step("held_cnt",  S_FETCH, C_FETCH_WAIT, 32'hFFFF_FFFF);
        mem_ready = 1'b1;
        step("wrap_fetch", S_FETCH,    C_FETCH_RDY, 32'hFFFF_FFFF);
        step("wrap_dec",   S_DECODE,   C_DECODE,    32'hFFFF_FFFF);
        step("wrap_addr",  S_MEM_ADDR, C_MEM_ADDR,  32'hFFFF_FFFF);
        step("wrap_wr",    S_MEM_WR,   C_MEM_WR,    32'hFFFF_FFFF);
        step("wrap_done",  S_FETCH,    C_FETCH_RDY, 32'h0000_0000);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            $display("FAIL drain: got %0d unchecked expectations, want 0", sb_q.size());
            miscompares += sb_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
